// File: rtl/rca_seq_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple-carry slice, LSB nibble first.
// Optional subtract mode is enabled by defining RCA_SEQ_ADDER_SUB_EN.

module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[4];
endmodule

module rca_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    count_reg;

  logic [3:0]       nib;
  logic             nib_cout;
  logic             accept, last_nib;
  logic [WIDTH-1:0] b_load, sum_shift;
  logic             carry_load;

  rca u_rca (
    .a    (a_sh_reg[3:0]),
    .b    (b_sh_reg[3:0]),
    .cin  (carry_reg),
    .s    (nib),
    .cout (nib_cout)
  );

  assign accept   = (state_reg == IDLE) && in_valid;
  assign last_nib = (count_reg == CW'(NIBBLES - 1));

`ifdef RCA_SEQ_ADDER_SUB_EN
  // Subtraction as a + ~b + 1; the forced carry replaces cin.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  // Nibbles enter from the top so the LSB nibble ends up at bit 0 after NIBBLES shifts.
  generate
    if (NIBBLES > 1) begin : g_shift_wide
      assign sum_shift = {nib, sum_reg[WIDTH-1:4]};
    end else begin : g_shift_single
      assign sum_shift = nib;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_nib) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      count_reg <= '0;
    end else if (accept) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b_load;
      sum_reg   <= '0;
      carry_reg <= carry_load;
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg  <= a_sh_reg >> 4;
      b_sh_reg  <= b_sh_reg >> 4;
      sum_reg   <= sum_shift;
      carry_reg <= nib_cout;
      count_reg <= count_reg + 1'b1;
      if (last_nib) begin
        cout_reg <= nib_cout;
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed, table-driven bench for rca_seq_adder at WIDTH=16.
// Subtract vectors are exercised only when RCA_SEQ_ADDER_SUB_EN is defined.

module tb_rca_seq_adder;
  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b, sum;
  logic             cin, cout, busy;
  logic             out_valid, out_ready;
  logic             sub;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rca_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef RCA_SEQ_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    int          hold;
    logic        tied;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction: accept, latency count, result check, optional backpressure, return.
  task automatic do_txn(input vec_t v, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    out_ready = v.tied;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = ~v.cin; sub = ~v.sub;
    check({tag, "_sum_clr"}, 32'(sum), 32'd0);
    check({tag, "_busy_ready"}, {30'd0, busy, in_ready}, 32'd2);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
      if (!out_valid) check({tag, "_ready_run"}, 32'(in_ready), 32'd0);
    end
    check({tag, "_latency"}, 32'(n), 32'(NIBBLES));
    check({tag, "_sum"}, 32'(sum), 32'(v.sum));
    check({tag, "_cout"}, 32'(cout), 32'(v.cout));
    for (int i = 0; i < v.hold; i++) begin
      in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
      @(posedge clk); #1;
      check({tag, "_bp_valid"}, {30'd0, out_valid, in_ready}, 32'd2);
      check({tag, "_bp_result"}, {15'd0, cout, sum}, {15'd0, v.cout, v.sum});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = v.tied;
    check({tag, "_ret_flags"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
    check({tag, "_ret_result"}, {15'd0, cout, sum}, {15'd0, v.cout, v.sum});
    $display("txn %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d lat=%0d",
             tag, v.a, v.b, v.cin, v.sub, sum, cout, n);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 0, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 5, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 0, 1'b0};
    vecs[5] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 0, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 0, 1'b1};
    vecs[7] = '{16'hFFFE, 16'h0003, 1'b0, 1'b0, 16'h0001, 1'b1, 0, 1'b1};
    vecs[8] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("reset_flags", {28'd0, in_ready, out_valid, busy, cout}, 32'd8);
    check("reset_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i], $sformatf("v%0d", i));
    end
    out_ready = 1'b0;
    @(posedge clk); #1;

    // Abort two RUN cycles into a transaction.
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_flags", {28'd0, in_ready, out_valid, busy, cout}, 32'd8);
    check("abort_sum", 32'(sum), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    do_txn(vecs[8], "post_abort");

`ifdef RCA_SEQ_ADDER_SUB_EN
    begin
      vec_t s0, s1;
      s0 = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0, 1'b0};
      s1 = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 0, 1'b0};
      do_txn(s0, "sub0");
      do_txn(s1, "sub1");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
